// File: rtl/mem_responder_if.sv
// CPU-side request/response bundle of the memory responder (4-phase ok/en handshake).
interface mem_responder_if;
  logic        rq_r;
  logic        rq_w;
  logic        rq_s;
  logic [15:0] ad;
  logic [3:0]  nb;
  logic [15:0] dt_in;
  logic [15:0] dt_out;
  logic        ok;
  logic        en;

  modport master (output rq_r, rq_w, rq_s, ad, nb, dt_in, input dt_out, ok, en);
  modport slave  (input rq_r, rq_w, rq_s, ad, nb, dt_in, output dt_out, ok, en);
endinterface

// File: rtl/mem_responder.sv
// Memory responder: maps {nb,page} to a physical frame, serves read/write/set-bits with a 4-phase ok/en handshake.
// Optional MEM_SBITS_EN adds the atomic set-bits (OR) access; without it rq_s is refused with en.
module mem_responder #(
  parameter int FRAMES  = 2,
  parameter int LATENCY = 1
) (
  input  logic           __clk,
  input  logic           clm,
  mem_responder_if.slave bus,
  output logic           busy,
  input  logic           map_we,
  input  logic [3:0]     map_nb,
  input  logic [3:0]     map_page,
  input  logic [3:0]     map_frame,
  input  logic           map_valid
);
  localparam int         DEPTH  = FRAMES * 4096;
  localparam int         AW     = $clog2(DEPTH);
  localparam logic [4:0] NFR    = 5'(FRAMES);
  localparam logic [2:0] LAT_M1 = 3'(LATENCY - 1);

  typedef struct packed {
    logic       valid;
    logic [3:0] frame;
  } map_ent_t;

`ifdef MEM_SBITS_EN
  typedef enum logic [2:0] {IDLE, LOOK, ACC, ACC2, WAIT, RESP, DROP} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOOK, ACC, WAIT, RESP, DROP} state_t;
`endif

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic        ok_q, ok_n, en_q, en_n;
  logic [15:0] ad_q, dt_q, rd_q;
  logic [3:0]  nb_q, frame_q;
  logic [2:0]  kind_q;        // {s, w, r}
  logic        req, legal, refuse, acc_done;
  logic        mem_we, mem_re;
  logic [15:0] mem_wd;
  logic [15:0] pa_full;
  logic [AW-1:0] pa;
  map_ent_t    look_ent;
  map_ent_t    map_tbl [256];
  logic [15:0] mem [DEPTH];

  assign req = bus.rq_r | bus.rq_w | bus.rq_s;

`ifdef MEM_SBITS_EN
  assign legal = $onehot(kind_q);
`else
  assign legal = $onehot(kind_q) && !kind_q[2];
`endif

  assign look_ent = map_tbl[{nb_q, ad_q[15:12]}];
  assign refuse   = !legal || !look_ent.valid || ({1'b0, look_ent.frame} >= NFR);
  assign pa_full  = {frame_q, ad_q[11:0]};
  assign pa       = pa_full[AW-1:0];

  assign bus.ok     = ok_q;
  assign bus.en     = en_q;
  assign bus.dt_out = (ok_q && !kind_q[1]) ? rd_q : 16'h0000;
  assign busy       = (state != IDLE);

  always_ff @(posedge __clk or posedge clm) begin
    if (clm) begin
      state   <= IDLE;
      cnt     <= '0;
      ok_q    <= 1'b0;
      en_q    <= 1'b0;
      ad_q    <= '0;
      dt_q    <= '0;
      nb_q    <= '0;
      kind_q  <= '0;
      frame_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ok_q  <= ok_n;
      en_q  <= en_n;
      if (state == IDLE && req) begin
        ad_q   <= bus.ad;
        dt_q   <= bus.dt_in;
        nb_q   <= bus.nb;
        kind_q <= {bus.rq_s, bus.rq_w, bus.rq_r};
      end
      if (state == LOOK) frame_q <= look_ent.frame;
    end
  end

  // Segment map: nb=0 starts identity-mapped over the populated frames.
  always_ff @(posedge __clk or posedge clm) begin
    if (clm) begin
      for (int i = 0; i < 256; i++) begin
        map_tbl[i].valid <= (i < FRAMES) && (i < 16);
        map_tbl[i].frame <= (i < 16) ? 4'(i) : 4'd0;
      end
    end else if (map_we) begin
      map_tbl[{map_nb, map_page}] <= '{valid: map_valid, frame: map_frame};
    end
  end

  // Storage is never reset; enables come from the FSM so a clear mid-access suppresses the write.
  always_ff @(posedge __clk) begin
    if (mem_we) mem[pa] <= mem_wd;
    if (mem_re) rd_q <= mem[pa];
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    ok_n     = ok_q;
    en_n     = en_q;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    mem_wd   = dt_q;
    acc_done = 1'b0;
    unique case (state)
      IDLE: if (req) state_n = LOOK;
      LOOK: begin
        if (refuse) begin
          state_n = RESP;
          en_n    = 1'b1;
        end else begin
          state_n = ACC;
        end
      end
      ACC: begin
        if (kind_q[1]) mem_we = 1'b1;
        else           mem_re = 1'b1;
`ifdef MEM_SBITS_EN
        if (kind_q[2]) state_n = ACC2;
        else           acc_done = 1'b1;
`else
        acc_done = 1'b1;
`endif
      end
`ifdef MEM_SBITS_EN
      ACC2: begin
        mem_we   = 1'b1;
        mem_wd   = rd_q | dt_q;
        acc_done = 1'b1;
      end
`endif
      WAIT: begin
        if (cnt == 3'd0) begin
          state_n = RESP;
          ok_n    = 1'b1;
        end else begin
          cnt_n = cnt - 3'd1;
        end
      end
      RESP, DROP: begin
        if (!req) begin
          state_n = IDLE;
          ok_n    = 1'b0;
          en_n    = 1'b0;
        end else begin
          state_n = DROP;
        end
      end
      default: state_n = IDLE;
    endcase
    if (acc_done) begin
      if (LATENCY == 0) begin
        state_n = RESP;
        ok_n    = 1'b1;
      end else begin
        state_n = WAIT;
        cnt_n   = LAT_M1;
      end
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (FRAMES=2, LATENCY=1).
module tb_mem_responder;
  localparam int LAT = 1;
  localparam logic [2:0] K_R = 3'b001, K_W = 3'b010, K_S = 3'b100;

  logic clk = 1'b0;
  logic clm = 1'b1;
  logic busy;
  logic map_we = 1'b0, map_valid = 1'b0;
  logic [3:0] map_nb = '0, map_page = '0, map_frame = '0;
  int n_cmp = 0, n_bad = 0;

  mem_responder_if bus();

  mem_responder #(.FRAMES(2), .LATENCY(LAT)) dut (
    .__clk(clk), .clm(clm), .bus(bus), .busy(busy),
    .map_we(map_we), .map_nb(map_nb), .map_page(map_page),
    .map_frame(map_frame), .map_valid(map_valid)
  );

  always #5 clk = ~clk;

  task automatic start_req(input logic [2:0] k, input logic [3:0] n, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    {bus.rq_s, bus.rq_w, bus.rq_r} = k;
    bus.nb = n; bus.ad = a; bus.dt_in = d;
  endtask

  // Counts rising edges until ok/en; address/data are scrambled after cycle 0.
  task automatic wait_resp(output int edges);
    edges = 0;
    while (!(bus.ok || bus.en) && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) begin
        bus.ad = ~bus.ad; bus.dt_in = ~bus.dt_in; bus.nb = ~bus.nb;
      end
    end
  endtask

  task automatic drop_req();
    @(negedge clk);
    {bus.rq_s, bus.rq_w, bus.rq_r} = 3'b000;
    @(posedge clk); #1;
  endtask

  task automatic xact(input logic [2:0] k, input logic [3:0] n, input logic [15:0] a, input logic [15:0] d,
                      output int edges, output logic o, output logic e, output logic [15:0] q);
    start_req(k, n, a, d);
    wait_resp(edges);
    o = bus.ok; e = bus.en; q = bus.dt_out;
    drop_req();
  endtask

  task automatic map_write(input logic [3:0] n, input logic [3:0] p, input logic [3:0] f, input logic v);
    @(negedge clk);
    map_we = 1'b1; map_nb = n; map_page = p; map_frame = f; map_valid = v;
    @(negedge clk);
    map_we = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (bus.ok !== 1'b0)        begin n_bad++; $display("FAIL reset_ok: got %b want 0", bus.ok); end
    n_cmp++; if (bus.en !== 1'b0)        begin n_bad++; $display("FAIL reset_en: got %b want 0", bus.en); end
    n_cmp++; if (bus.dt_out !== 16'h0)   begin n_bad++; $display("FAIL reset_dt: got %h want 0000", bus.dt_out); end
    n_cmp++; if (busy !== 1'b0)          begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk); clm = 1'b0;
  endtask

  task automatic test_write_read();
    int ed; logic o, e; logic [15:0] q;
    xact(K_W, 4'd0, 16'h0010, 16'h1234, ed, o, e, q);
    n_cmp++; if (ed !== 3 + LAT)  begin n_bad++; $display("FAIL wr_lat: got %0d want %0d", ed, 3 + LAT); end
    n_cmp++; if ({o, e} !== 2'b10) begin n_bad++; $display("FAIL wr_okn: got %b want 10", {o, e}); end
    n_cmp++; if (q !== 16'h0000)  begin n_bad++; $display("FAIL wr_dt: got %h want 0000", q); end
    xact(K_R, 4'd0, 16'h0010, 16'h0000, ed, o, e, q);
    n_cmp++; if (ed !== 3 + LAT)  begin n_bad++; $display("FAIL rd_lat: got %0d want %0d", ed, 3 + LAT); end
    n_cmp++; if ({o, e} !== 2'b10) begin n_bad++; $display("FAIL rd_okn: got %b want 10", {o, e}); end
    n_cmp++; if (q !== 16'h1234)  begin n_bad++; $display("FAIL rd_dt: got %h want 1234", q); end
  endtask

  task automatic test_unmapped();
    int ed; logic o, e; logic [15:0] q;
    xact(K_R, 4'd3, 16'h2000, 16'h0000, ed, o, e, q);
    n_cmp++; if (ed !== 2)         begin n_bad++; $display("FAIL nomap_lat: got %0d want 2", ed); end
    n_cmp++; if ({o, e} !== 2'b01) begin n_bad++; $display("FAIL nomap_okn: got %b want 01", {o, e}); end
    n_cmp++; if (q !== 16'h0000)   begin n_bad++; $display("FAIL nomap_dt: got %h want 0000", q); end
    xact(K_W, 4'd3, 16'h0010, 16'hDEAD, ed, o, e, q);
    n_cmp++; if ({o, e} !== 2'b01) begin n_bad++; $display("FAIL nomap_wr: got %b want 01", {o, e}); end
    xact(K_R, 4'd0, 16'h0010, 16'h0000, ed, o, e, q);
    n_cmp++; if (q !== 16'h1234)   begin n_bad++; $display("FAIL nomap_keep: got %h want 1234", q); end
  endtask

  task automatic test_map();
    int ed; logic o, e; logic [15:0] q;
    map_write(4'd3, 4'd2, 4'd1, 1'b1);
    xact(K_W, 4'd3, 16'h2005, 16'hBEEF, ed, o, e, q);
    n_cmp++; if ({o, e} !== 2'b10) begin n_bad++; $display("FAIL map_wr: got %b want 10", {o, e}); end
    xact(K_R, 4'd0, 16'h1005, 16'h0000, ed, o, e, q);
    n_cmp++; if (q !== 16'hBEEF)   begin n_bad++; $display("FAIL map_alias: got %h want beef", q); end
    xact(K_R, 4'd0, 16'h2000, 16'h0000, ed, o, e, q);
    n_cmp++; if ({o, e} !== 2'b01) begin n_bad++; $display("FAIL frame_range: got %b want 01", {o, e}); end
  endtask

  task automatic test_sbits();
    int ed; logic o, e; logic [15:0] q;
    xact(K_W, 4'd0, 16'h0020, 16'h00F0, ed, o, e, q);
    xact(K_S, 4'd0, 16'h0020, 16'h0F01, ed, o, e, q);
`ifdef MEM_SBITS_EN
    n_cmp++; if (ed !== 4 + LAT)   begin n_bad++; $display("FAIL sb_lat: got %0d want %0d", ed, 4 + LAT); end
    n_cmp++; if ({o, e} !== 2'b10) begin n_bad++; $display("FAIL sb_okn: got %b want 10", {o, e}); end
    n_cmp++; if (q !== 16'h00F0)   begin n_bad++; $display("FAIL sb_old: got %h want 00f0", q); end
    xact(K_R, 4'd0, 16'h0020, 16'h0000, ed, o, e, q);
    n_cmp++; if (q !== 16'h0FF1)   begin n_bad++; $display("FAIL sb_new: got %h want 0ff1", q); end
`else
    n_cmp++; if (ed !== 2)         begin n_bad++; $display("FAIL sb_lat: got %0d want 2", ed); end
    n_cmp++; if ({o, e} !== 2'b01) begin n_bad++; $display("FAIL sb_okn: got %b want 01", {o, e}); end
    xact(K_R, 4'd0, 16'h0020, 16'h0000, ed, o, e, q);
    n_cmp++; if (q !== 16'h00F0)   begin n_bad++; $display("FAIL sb_keep: got %h want 00f0", q); end
`endif
  endtask

  task automatic test_handshake();
    int ed, held, pulses; logic o, e; logic [15:0] q;
    xact(K_R | K_W, 4'd0, 16'h0010, 16'h0000, ed, o, e, q);
    n_cmp++; if ({o, e} !== 2'b01) begin n_bad++; $display("FAIL multi_hot: got %b want 01", {o, e}); end
    start_req(K_R, 4'd0, 16'h1005, 16'h0000);
    wait_resp(ed);
    held = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.ok === 1'b1 && bus.dt_out === 16'hBEEF) held++;
    end
    n_cmp++; if (held !== 10) begin n_bad++; $display("FAIL ok_hold: got %0d want 10", held); end
    @(negedge clk); bus.rq_r = 1'b0; #1;
    n_cmp++; if (bus.ok !== 1'b1) begin n_bad++; $display("FAIL ok_until_edge: got %b want 1", bus.ok); end
    @(posedge clk); #1;
    n_cmp++; if ({bus.ok, bus.en, busy} !== 3'b000 || bus.dt_out !== 16'h0)
      begin n_bad++; $display("FAIL drop_clear: got %b/%h want 000/0000", {bus.ok, bus.en, busy}, bus.dt_out); end
    // Early drop: write still commits, ok pulses for exactly one cycle.
    start_req(K_W, 4'd0, 16'h0030, 16'h5A5A);
    @(posedge clk); #1;
    @(negedge clk); bus.rq_w = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.ok === 1'b1) pulses++;
    end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL early_pulse: got %0d want 1", pulses); end
    xact(K_R, 4'd0, 16'h0030, 16'h0000, ed, o, e, q);
    n_cmp++; if (q !== 16'h5A5A) begin n_bad++; $display("FAIL early_commit: got %h want 5a5a", q); end
  endtask

  task automatic test_clear_mid_access();
    int ed; logic o, e; logic [15:0] q;
    start_req(K_W, 4'd0, 16'h0040, 16'h7777);
    @(posedge clk); @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL acc_busy: got %b want 1", busy); end
    #2; clm = 1'b1; bus.rq_w = 1'b0; #1;
    n_cmp++; if ({bus.ok, bus.en, busy} !== 3'b000)
      begin n_bad++; $display("FAIL clm_async: got %b want 000", {bus.ok, bus.en, busy}); end
    @(negedge clk); clm = 1'b0;
    xact(K_R, 4'd3, 16'h2005, 16'h0000, ed, o, e, q);
    n_cmp++; if ({o, e} !== 2'b01) begin n_bad++; $display("FAIL map_reset: got %b want 01", {o, e}); end
    xact(K_R, 4'd0, 16'h0040, 16'h0000, ed, o, e, q);
    n_cmp++; if ({o, e} !== 2'b10 || ed !== 3 + LAT)
      begin n_bad++; $display("FAIL post_clm_rd: got %b/%0d want 10/%0d", {o, e}, ed, 3 + LAT); end
  endtask

  initial begin
    bus.rq_r = 1'b0; bus.rq_w = 1'b0; bus.rq_s = 1'b0;
    bus.ad = '0; bus.nb = '0; bus.dt_in = '0;
    test_reset();
    test_write_read();
    test_unmapped();
    test_map();
    test_sbits();
    test_handshake();
    test_clear_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
